// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Results and flags are registered; start is honoured only in IDLE.
module seq_restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);
   // Encoding chosen so busy and done are direct flop outputs.
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FIN = 2'b10} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] q, d, q_nxt;
   logic [WIDTH:0] r, t, r_nxt;
   logic [CW-1:0] cnt;
   logic accept, last;
   always_comb begin
      t      = {r[WIDTH-1:0], q[WIDTH-1]} - {1'b0, d};
      q_nxt  = {q[WIDTH-2:0], ~t[WIDTH]};
      r_nxt  = t[WIDTH] ? {r[WIDTH-1:0], q[WIDTH-1]} : t;
      accept = (state == IDLE) && start;
      last   = (state == RUN) && (cnt == '0);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   always_comb
      state_nxt = (state == IDLE) ? (start ? ((divisor == '0) ? FIN : RUN) : IDLE) :
                  (state == RUN)  ? ((cnt == '0) ? FIN : RUN) : IDLE;
   always_comb begin
      busy = state[0];
      done = state[1];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         q   <= '0;
         d   <= '0;
         r   <= '0;
         cnt <= '0;
      end else if (accept) begin
         q   <= dividend;
         d   <= divisor;
         r   <= '0;
         cnt <= CW'(WIDTH - 1);
      end else if (state == RUN) begin
         q   <= q_nxt;
         r   <= r_nxt;
         cnt <= cnt - 1'b1;
      end
   // Results load on the edge entering FIN, from the final iteration's values.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept && divisor == '0) begin
         quotient    <= '1;
         remainder   <= dividend;
         div_by_zero <= 1'b1;
      end else if (last) begin
         quotient    <= q_nxt;
         remainder   <= r_nxt[WIDTH-1:0];
         div_by_zero <= 1'b0;
      end
endmodule
